// File: rtl/adcdac_2g_pkg.sv
// Shared constants for the 2 Gsps ADC/DAC UART control link:
// frame opcodes, response bytes and the command responder FSM encoding.
package adcdac_2g_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;
  localparam logic [7:0] RSP_WACK = 8'h4B;
  localparam logic [7:0] RSP_BAD  = 8'h3F;
  localparam logic [7:0] RSP_FILL = 8'hFF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR    = 4'd1,
    ST_DHI     = 4'd2,
    ST_DLO     = 4'd3,
    ST_WR      = 4'd4,
    ST_RD_REQ  = 4'd5,
    ST_RD_WAIT = 4'd6,
    ST_RESP    = 4'd7,
    ST_ERR     = 4'd8
  } state_e;

  // Byte [0] is transmitted first.
  typedef logic [3:0][7:0] resp_buf_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/adcdac_2g_cmd_responder_if.sv
// UART byte streams and local register bus of the command responder.
// master = responder side, slave = UART/register-file side.
interface adcdac_2g_cmd_responder_if;
  logic [7:0]  in_data;
  logic        in_val;
  logic [7:0]  out_data;
  logic        out_val;
  logic        out_full;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic [15:0] reg_rdata;
  logic        reg_rvalid;

  modport master (
    input  in_data, in_val, out_full, reg_rdata, reg_rvalid,
    output out_data, out_val, reg_addr, reg_wdata, reg_we, reg_re
  );

  modport slave (
    output in_data, in_val, out_full, reg_rdata, reg_rvalid,
    input  out_data, out_val, reg_addr, reg_wdata, reg_we, reg_re
  );
endinterface

// File: rtl/adcdac_2g_resp_tx.sv
// Response buffer: holds up to four bytes and writes them to the UART tx
// buffer one per cycle, stalling while the tx buffer reports full.
module adcdac_2g_resp_tx
  import adcdac_2g_pkg::*;
(
  input  logic       fpga_clk,
  input  logic       fpga_rst,
  input  logic       load,
  input  logic [2:0] load_len,
  input  resp_buf_t  load_bytes,
  input  logic       out_full,
  output logic [7:0] out_data,
  output logic       out_val,
  output logic       busy
);

  resp_buf_t  bytes_r;
  logic [2:0] len_r;
  logic [2:0] idx_r;
  logic       active_r;
  logic       out_val_r;
  logic [7:0] out_data_r;

  // Load/emit sequencer; the first byte leaves on the load edge so a
  // response starts the cycle after its data is known.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      bytes_r    <= {8'h00, 8'h00, 8'h00, 8'h00};
      len_r      <= 3'd0;
      idx_r      <= 3'd0;
      active_r   <= 1'b0;
      out_val_r  <= 1'b0;
      out_data_r <= 8'h00;
    end else if (load) begin
      bytes_r <= load_bytes;
      len_r   <= load_len;
      if (!out_full) begin
        out_val_r  <= 1'b1;
        out_data_r <= load_bytes[0];
        idx_r      <= 3'd1;
        active_r   <= (load_len > 3'd1);
      end else begin
        out_val_r <= 1'b0;
        idx_r     <= 3'd0;
        active_r  <= 1'b1;
      end
    end else if (active_r && !out_full) begin
      out_val_r  <= 1'b1;
      out_data_r <= bytes_r[idx_r[1:0]];
      idx_r      <= idx_r + 3'd1;
      active_r   <= ((idx_r + 3'd1) != len_r);
    end else begin
      out_val_r <= 1'b0;
    end
  end

  assign out_data = out_data_r;
  assign out_val  = out_val_r;
  assign busy     = active_r;

endmodule

// File: rtl/adcdac_2g_cmd_responder.sv
// Board-side command responder: parses read/write frames from the UART rx
// byte stream, drives the local register bus and queues the response bytes.
module adcdac_2g_cmd_responder
  import adcdac_2g_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES    = 32'd4_000_000,
  parameter logic [15:0] RD_TIMEOUT_CYCLES = 16'd1024
) (
  input  logic                        fpga_clk,
  input  logic                        fpga_rst,
  adcdac_2g_cmd_responder_if.master   bus,
  output logic                        overrun,
  output logic [7:0]                  err_cnt
);

  state_e      state_r;
  state_e      state_next_s;
  logic [7:0]  hold_data_r;
  logic        hold_valid_r;
  logic        consume_s;
  logic        is_read_r;
  logic [31:0] idle_cnt_r;
  logic        frame_to_s;
  logic [15:0] rd_cnt_r;
  logic        rd_to_s;
  logic [7:0]  reg_addr_r;
  logic [15:0] reg_wdata_r;
  logic        reg_we_r;
  logic        reg_re_r;
  logic        load_s;
  logic [2:0]  load_len_s;
  resp_buf_t   load_bytes_s;
  logic        err_inc_s;
  logic        overrun_r;
  logic [7:0]  err_cnt_r;
  logic        tx_busy_s;
  logic [7:0]  tx_data_s;
  logic        tx_val_s;

  // FSM state register.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state, byte consumption, response load and error events.
  always_comb begin
    state_next_s = state_r;
    consume_s    = 1'b0;
    load_s       = 1'b0;
    load_len_s   = 3'd0;
    load_bytes_s = {8'h00, 8'h00, 8'h00, 8'h00};
    err_inc_s    = 1'b0;
    frame_to_s   = (idle_cnt_r == (TIMEOUT_CYCLES - 32'd1));
    rd_to_s      = (rd_cnt_r == (RD_TIMEOUT_CYCLES - 16'd1));
    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) begin
          consume_s = 1'b1;
          if ((hold_data_r == OP_WRITE) || (hold_data_r == OP_READ)) begin
            state_next_s = ST_ADDR;
          end else begin
            state_next_s = ST_ERR;
          end
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_ADDR, ST_DHI, ST_DLO: begin
        if (hold_valid_r) begin
          consume_s = 1'b1;
          if (state_r == ST_ADDR) begin
            state_next_s = is_read_r ? ST_RD_REQ : ST_DHI;
          end else if (state_r == ST_DHI) begin
            state_next_s = ST_DLO;
          end else begin
            state_next_s = ST_WR;
          end
        end else if (frame_to_s) begin
          state_next_s = ST_IDLE;
          err_inc_s    = 1'b1;
        end else begin
          state_next_s = state_r;
        end
      end
      ST_WR: begin
        load_s          = 1'b1;
        load_len_s      = 3'd1;
        load_bytes_s[0] = RSP_WACK;
        state_next_s    = ST_RESP;
      end
      ST_RD_REQ: begin
        state_next_s = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        load_bytes_s[0] = OP_READ;
        load_bytes_s[1] = reg_addr_r;
        load_len_s      = 3'd4;
        if (bus.reg_rvalid) begin
          load_s          = 1'b1;
          load_bytes_s[2] = bus.reg_rdata[15:8];
          load_bytes_s[3] = bus.reg_rdata[7:0];
          state_next_s    = ST_RESP;
        end else if (rd_to_s) begin
          load_s          = 1'b1;
          load_bytes_s[2] = RSP_FILL;
          load_bytes_s[3] = RSP_FILL;
          err_inc_s       = 1'b1;
          state_next_s    = ST_RESP;
        end else begin
          state_next_s = ST_RD_WAIT;
        end
      end
      ST_ERR: begin
        load_s          = 1'b1;
        load_len_s      = 3'd1;
        load_bytes_s[0] = RSP_BAD;
        err_inc_s       = 1'b1;
        state_next_s    = ST_RESP;
      end
      ST_RESP: begin
        if (!tx_busy_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // One-byte input holding register; a byte arriving while it is still
  // occupied and not being consumed is lost and flagged.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      hold_data_r  <= 8'h00;
      hold_valid_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (bus.in_val) begin
      if (!hold_valid_r || consume_s) begin
        hold_data_r  <= bus.in_data;
        hold_valid_r <= 1'b1;
      end else begin
        overrun_r <= 1'b1;
      end
    end else if (consume_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  // Inter-byte and read-data timeout counters.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      idle_cnt_r <= 32'd0;
      rd_cnt_r   <= 16'd0;
    end else begin
      if (consume_s || !((state_r == ST_ADDR) || (state_r == ST_DHI) || (state_r == ST_DLO))) begin
        idle_cnt_r <= 32'd0;
      end else begin
        idle_cnt_r <= idle_cnt_r + 32'd1;
      end
      if (state_r != ST_RD_WAIT) begin
        rd_cnt_r <= 16'd0;
      end else begin
        rd_cnt_r <= rd_cnt_r + 16'd1;
      end
    end
  end

  // Frame fields; address and write data persist until the next frame.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      is_read_r   <= 1'b0;
      reg_addr_r  <= 8'h00;
      reg_wdata_r <= 16'h0000;
    end else if (consume_s) begin
      case (state_r)
        ST_IDLE: is_read_r          <= (hold_data_r == OP_READ);
        ST_ADDR: reg_addr_r         <= hold_data_r;
        ST_DHI:  reg_wdata_r[15:8]  <= hold_data_r;
        ST_DLO:  reg_wdata_r[7:0]   <= hold_data_r;
        default: is_read_r          <= is_read_r;
      endcase
    end
  end

  // Registered bus strobes and the saturating error counter.
  always_ff @(posedge fpga_clk) begin
    if (fpga_rst) begin
      reg_we_r  <= 1'b0;
      reg_re_r  <= 1'b0;
      err_cnt_r <= 8'h00;
    end else begin
      reg_we_r <= (state_next_s == ST_WR);
      reg_re_r <= (state_next_s == ST_RD_REQ);
      if (err_inc_s) begin
        err_cnt_r <= sat_inc8(err_cnt_r);
      end
    end
  end

  adcdac_2g_resp_tx u_resp_tx (
    .fpga_clk   (fpga_clk),
    .fpga_rst   (fpga_rst),
    .load       (load_s),
    .load_len   (load_len_s),
    .load_bytes (load_bytes_s),
    .out_full   (bus.out_full),
    .out_data   (tx_data_s),
    .out_val    (tx_val_s),
    .busy       (tx_busy_s)
  );

  assign bus.out_data  = tx_data_s;
  assign bus.out_val   = tx_val_s;
  assign bus.reg_addr  = reg_addr_r;
  assign bus.reg_wdata = reg_wdata_r;
  assign bus.reg_we    = reg_we_r;
  assign bus.reg_re    = reg_re_r;
  assign overrun       = overrun_r;
  assign err_cnt       = err_cnt_r;

endmodule

// File: tb/tb_adcdac_2g_cmd_responder.sv
// Self-checking bench for adcdac_2g_cmd_responder: directed frames from the
// test plan plus random frames scored against a frame-level reference model.
module tb_adcdac_2g_cmd_responder;

  localparam int TO   = 100;
  localparam int RDTO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overrun;
  logic [7:0] err_cnt;

  adcdac_2g_cmd_responder_if bus();

  adcdac_2g_cmd_responder #(
    .TIMEOUT_CYCLES    (32'(TO)),
    .RD_TIMEOUT_CYCLES (16'(RDTO))
  ) dut (
    .fpga_clk (clk),
    .fpga_rst (rst),
    .bus      (bus),
    .overrun  (overrun),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0]  got_q[$];
  int          got_cyc_q[$];
  logic [23:0] we_q[$];
  int          we_cyc;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_we[$];
  logic [7:0]  exp_err = 8'h00;
  int          last_in_cyc;
  int          last_rv_cyc;

  bit          rd_respond = 1'b1;
  int          rd_delay = 1;
  logic [15:0] rd_value = 16'h0000;
  int          stray_req = 0;
  bit          full_force = 1'b0;
  bit          rand_full = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Output monitor: sampled 1 unit after the clock edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (bus.out_val) begin
      got_q.push_back(bus.out_data);
      got_cyc_q.push_back(cyc);
    end
    if (bus.reg_we) begin
      we_q.push_back({bus.reg_addr, bus.reg_wdata});
      we_cyc = cyc;
    end
    if (bus.out_full) begin
      checks++;
      assert (!bus.out_val) else begin
        errors++;
        $error("FAIL out_val_while_full observed=1 expected=0");
      end
    end
  end

  // Register file stand-in: answers reg_re after rd_delay cycles.
  initial begin
    int stray_done;
    stray_done = 0;
    bus.reg_rvalid = 1'b0;
    bus.reg_rdata  = 16'h0000;
    forever begin
      @(posedge clk);
      #1;
      if (bus.reg_re && rd_respond) begin
        repeat (rd_delay + 1) @(negedge clk);
        bus.reg_rvalid = 1'b1;
        bus.reg_rdata  = rd_value;
        last_rv_cyc    = cyc;
        @(negedge clk);
        bus.reg_rvalid = 1'b0;
        bus.reg_rdata  = 16'h0000;
      end else if (stray_req != stray_done) begin
        @(negedge clk);
        bus.reg_rvalid = 1'b1;
        bus.reg_rdata  = 16'hDEAD;
        @(negedge clk);
        bus.reg_rvalid = 1'b0;
        bus.reg_rdata  = 16'h0000;
        stray_done++;
      end
    end
  end

  // Tx-buffer full flag: forced by the sequence or randomly toggled.
  initial forever begin
    @(negedge clk);
    bus.out_full = full_force || (rand_full && ($urandom_range(0, 3) == 0));
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.in_val  = 1'b1;
    bus.in_data = b;
    last_in_cyc = cyc;
    @(negedge clk);
    bus.in_val  = 1'b0;
    bus.in_data = 8'h00;
    repeat (gap) @(negedge clk);
  endtask

  function automatic logic [7:0] err_add(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int gap);
    send_byte(8'h57, gap);
    send_byte(a, gap);
    send_byte(d[15:8], gap);
    send_byte(d[7:0], gap);
    exp_q.push_back(8'h4B);
    exp_we.push_back({a, d});
  endtask

  task automatic do_read(input logic [7:0] a, input bit resp, input int dly,
                         input logic [15:0] d, input int gap);
    rd_respond = resp;
    rd_delay   = dly;
    rd_value   = d;
    send_byte(8'h52, gap);
    send_byte(a, gap);
    exp_q.push_back(8'h52);
    exp_q.push_back(a);
    exp_q.push_back(resp ? d[15:8] : 8'hFF);
    exp_q.push_back(resp ? d[7:0] : 8'hFF);
    if (!resp) exp_err = err_add(exp_err);
  endtask

  task automatic do_bad(input logic [7:0] b, input int gap);
    send_byte(b, gap);
    exp_q.push_back(8'h3F);
    exp_err = err_add(exp_err);
  endtask

  task automatic wait_frame(input string tag);
    int t;
    t = 0;
    while (got_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_wait"}, 32'(got_q.size() >= exp_q.size()), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic compare_frame(input string tag);
    logic [7:0]  eb;
    logic [23:0] ew;
    chk({tag, "_nbytes"}, 32'(got_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      eb = exp_q.pop_front();
      if (got_q.size() > 0) chk({tag, "_byte"}, 32'(got_q.pop_front()), 32'(eb));
    end
    chk({tag, "_nwe"}, 32'(we_q.size()), 32'(exp_we.size()));
    while (exp_we.size() > 0) begin
      ew = exp_we.pop_front();
      if (we_q.size() > 0) chk({tag, "_we"}, 32'(we_q.pop_front()), 32'(ew));
    end
    chk({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
    got_q.delete();
    got_cyc_q.delete();
    we_q.delete();
  endtask

  initial begin
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] d;
    int          k;
    int          g;
    bus.in_val  = 1'b0;
    bus.in_data = 8'h00;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_val", 32'(bus.out_val), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_reg_we", 32'(bus.reg_we), 32'd0);
    chk("rst_reg_re", 32'(bus.reg_re), 32'd0);
    chk("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
    chk("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Write 57 10 AB CD, back-to-back bytes.
    do_write(8'h10, 16'hABCD, 0);
    wait_frame("wr");
    chk("wr_we_lat", 32'(we_cyc), 32'(last_in_cyc + 2));
    if (got_cyc_q.size() > 0) chk("wr_resp_lat", 32'(got_cyc_q[0]), 32'(we_cyc + 1));
    chk("wr_addr", 32'(bus.reg_addr), 32'h10);
    chk("wr_wdata", 32'(bus.reg_wdata), 32'hABCD);
    compare_frame("wr");

    // Stray read strobe outside a read is ignored.
    stray_req++;
    repeat (10) @(negedge clk);
    chk("stray_rvalid", 32'(got_q.size()), 32'd0);

    // Read 52 22, data three cycles after reg_re.
    do_read(8'h22, 1'b1, 3, 16'h1234, 0);
    wait_frame("rd");
    if (got_cyc_q.size() == 4) begin
      chk("rd_first_lat", 32'(got_cyc_q[0]), 32'(last_rv_cyc + 1));
      chk("rd_back2back", 32'(got_cyc_q[3]), 32'(got_cyc_q[0] + 3));
    end
    compare_frame("rd");

    // Same read, tx buffer full for 20 cycles mid-response.
    do_read(8'h22, 1'b1, 3, 16'h1234, 0);
    begin
      int t;
      t = 0;
      while (got_q.size() < 1 && t < 500) begin
        @(negedge clk);
        t++;
      end
    end
    full_force = 1'b1;
    repeat (20) @(negedge clk);
    full_force = 1'b0;
    wait_frame("rdfull");
    if (got_cyc_q.size() == 4) chk("rdfull_stall", 32'((got_cyc_q[3] - got_cyc_q[0]) >= 20), 32'd1);
    compare_frame("rdfull");

    // Bad opcode, then a normal write.
    do_bad(8'h41, 0);
    wait_frame("bad");
    compare_frame("bad");
    do_write(8'h01, 16'h0005, 1);
    wait_frame("afterbad");
    compare_frame("afterbad");

    // Partial frame, then silence past the frame timeout.
    send_byte(8'h57, 0);
    send_byte(8'h10, 0);
    repeat (TO + 3) @(negedge clk);
    exp_err = err_add(exp_err);
    compare_frame("frame_to");
    do_write(8'h33, 16'h1357, 2);
    wait_frame("after_to");
    compare_frame("after_to");

    // Read that never gets data.
    do_read(8'h44, 1'b0, 1, 16'h0000, 0);
    wait_frame("rd_to");
    compare_frame("rd_to");

    // Random frames with random tx backpressure.
    rand_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 2);
      a = 8'($urandom_range(0, 255));
      d = 16'($urandom_range(0, 65535));
      g = $urandom_range(0, 3);
      if (k == 0) begin
        do_write(a, d, g);
      end else if (k == 1) begin
        do_read(a, 1'b1, $urandom_range(1, 6), d, g);
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'h57 || b == 8'h52) b = 8'h41;
        do_bad(b, g);
      end
      wait_frame("rnd");
      compare_frame("rnd");
    end
    rand_full = 1'b0;

    // Drive the error counter into saturation.
    for (int i = 0; i < 260; i++) begin
      do_bad(8'h00, 0);
      wait_frame("sat");
      exp_q.delete();
      got_q.delete();
      got_cyc_q.delete();
    end
    chk("err_saturated", 32'(err_cnt), 32'hFF);
    chk("overrun_clear", 32'(overrun), 32'd0);

    // Overrun: hold the response with full, then two back-to-back bytes.
    full_force = 1'b1;
    do_bad(8'h41, 4);
    send_byte(8'h41, 0);
    send_byte(8'h41, 0);
    exp_q.push_back(8'h3F);
    @(negedge clk);
    chk("overrun_set", 32'(overrun), 32'd1);
    full_force = 1'b0;
    wait_frame("ovr");
    compare_frame("ovr");

    // Reset while a response is stalled.
    full_force = 1'b1;
    do_read(8'h66, 1'b1, 1, 16'hBEEF, 0);
    exp_q.delete();
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    full_force = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstmid_nbytes", 32'(got_q.size()), 32'd0);
    chk("rstmid_overrun", 32'(overrun), 32'd0);
    chk("rstmid_err", 32'(err_cnt), 32'd0);
    chk("rstmid_addr", 32'(bus.reg_addr), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adcdac_2g_cmd_responder.md
# adcdac_2g_cmd_responder

Board-side command responder for the 2 Gsps ADC/DAC UART control link. Consumes the received byte stream (one-cycle `in_val` strobes from a `uart_rx6` capture stage), parses read/write register frames, drives a simple local register bus, and returns response bytes into a `uart_tx6` buffer with full-flag backpressure. It is the responder for the FPGA-side control interface, and sits between the board UART pair and the board register file.

## Interface
- `TIMEOUT_CYCLES`, 32'd4_000_000, idle cycles allowed between bytes of one frame before the partial frame is dropped.
- `RD_TIMEOUT_CYCLES`, 16'd1024, cycles allowed for `reg_rvalid` after `reg_re`.
- `fpga_clk` in 1: single clock for all logic.
- `fpga_rst` in 1: synchronous, active-high reset.
- `in_data` in 8: received byte.
- `in_val` in 1: one-cycle strobe qualifying `in_data`.
- `out_data` out 8: response byte to the UART tx buffer.
- `out_val` out 1: one-cycle write strobe; asserted only when `out_full`=0.
- `out_full` in 1: UART tx buffer full.
- `reg_addr` out 8: register address.
- `reg_wdata` out 16: write data.
- `reg_we` out 1: one-cycle write strobe.
- `reg_re` out 1: one-cycle read request.
- `reg_rdata` in 16: read data, valid with `reg_rvalid`.
- `reg_rvalid` in 1: read data strobe.
- `overrun` out 1: sticky; byte lost due to full holding register.
- `err_cnt` out 8: saturating count of bad opcodes, frame timeouts, read timeouts.

## Operation
- Frames: write = `0x57, addr, dhi, dlo`; read = `0x52, addr`.
- Responses: write → `0x4B`; read → `0x52, addr, dhi, dlo`; bad opcode → `0x3F`; read timeout → `0x52, addr, 0xFF, 0xFF`, `err_cnt`+1.
- Input holding register: one byte. `in_val` while full and not consumed that cycle → byte dropped, `overrun`<=1 (cleared only by reset).
- FSM states: IDLE, ADDR, DHI, DLO, WR, RD_REQ, RD_WAIT, RESP, ERR.
- IDLE: consume byte; `0x57`/`0x52` → ADDR; any other value → ERR.
- ADDR → DHI (write) or RD_REQ (read). DHI → DLO. DLO → WR.
- WR: `reg_we`=1 for one cycle → RESP (1 byte).
- RD_REQ: `reg_re`=1 for one cycle → RD_WAIT. RD_WAIT: on `reg_rvalid`, latch `reg_rdata` → RESP (4 bytes); after `RD_TIMEOUT_CYCLES` without it → RESP with 0xFFFF.
- ERR: enqueue `0x3F`, `err_cnt`+1 → RESP (1 byte).
- RESP: emits response bytes in order; each byte is issued on a cycle with `out_full`=0. Returns to IDLE after the last byte. Holding register still accepts input during RESP, but is not consumed there.
- Frame timeout: in ADDR/DHI/DLO with no byte for `TIMEOUT_CYCLES` → IDLE, no response, `err_cnt`+1.
- `err_cnt` saturates at 0xFF.
- `reg_addr` and `reg_wdata` hold their values from frame parse until the next frame overwrites them.

## Timing
- Reset values: `out_val`=0, `out_data`=0, `reg_we`=0, `reg_re`=0, `reg_addr`=0, `reg_wdata`=0, `overrun`=0, `err_cnt`=0, FSM=IDLE, holding register empty.
- Byte latency: `in_val` at cycle N → consumed by FSM no earlier than N+1.
- Write: last byte consumed at cycle M → `reg_we` at M+1 → `0x4B` with `out_val` at M+2 if `out_full`=0.
- Read: `reg_rvalid` at cycle K → first response byte at K+1; one byte per cycle while `out_full`=0.
- `out_full` high: `out_val` held low and byte index frozen; emission resumes the cycle after `out_full` drops.
- `reg_rvalid` outside RD_WAIT: ignored.
- Simultaneous `in_val` and consume of the held byte: new byte is accepted, with no overrun.
- Reset mid-frame or mid-response: return immediately to reset values; no further bytes emitted.

## Structure
- Shared package `adcdac_2g_pkg`: opcode and response byte constants (`0x57`, `0x52`, `0x4B`, `0x3F`) and the FSM state encoding.
- Sub-module `adcdac_2g_resp_tx`: 4-byte response shift buffer with length, index, and `out_full` gating.

## Test plan
- Write `57 10 AB CD` → one `reg_we` pulse with addr 0x10 and wdata 0xABCD; then `out_data`=0x4B.
- Read `52 22`, with `reg_rvalid` and rdata 0x1234 three cycles after `reg_re` → response bytes `52 22 12 34`, sent one per cycle.
- Same read with `out_full` held high for 20 cycles mid-response → byte order unchanged; no `out_val` while full.
- Opcode `0x41` → response `0x3F`, `err_cnt`=1; following `57 01 00 05` is processed normally.
- `57 10` then silence for `TIMEOUT_CYCLES`+1 cycles → no `reg_we`, no response, `err_cnt`+1; next frame parses correctly.
- Read with no `reg_rvalid` → after `RD_TIMEOUT_CYCLES`, response `52 addr FF FF`. Separately, two `in_val` strobes on consecutive cycles while held byte is unconsumed → `overrun`=1.
